// File: rtl/uart_prog_loader.sv
// Program loader: turns a UART byte stream (16-bit LE word count + payload) into memory word writes.
// Define UART_LOADER_CHECKSUM_EN to append and verify an 8-bit additive checksum byte per frame.
module uart_prog_loader #(
    parameter int unsigned           WORD_WIDTH     = 32,
    parameter int unsigned           ADDR_WIDTH     = 32,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR      = '0,
    parameter int unsigned           MAX_WORDS      = 256,
    parameter int unsigned           TIMEOUT_CYCLES = 5000000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  enable_i,
    input  logic                  abort_i,
    input  logic [7:0]            rx_data_i,
    input  logic                  rx_valid_i,
    output logic                  mem_we_o,
    output logic [ADDR_WIDTH-1:0] mem_addr_o,
    output logic [WORD_WIDTH-1:0] mem_wdata_o,
    output logic [15:0]           word_count_o,
    output logic                  cpu_hold_o,
    output logic                  done_o,
    output logic                  error_o
);
    localparam int unsigned BYTES = WORD_WIDTH / 8;
    localparam int unsigned BW    = (BYTES > 1) ? $clog2(BYTES) : 1;
    localparam int unsigned TW    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

`ifdef UART_LOADER_CHECKSUM_EN
    typedef enum logic [2:0] {S_IDLE, S_LEN0, S_LEN1, S_DATA, S_CSUM, S_DONE, S_ERROR} state_t;
    localparam state_t S_END = S_CSUM;
`else
    typedef enum logic [2:0] {S_IDLE, S_LEN0, S_LEN1, S_DATA, S_DONE, S_ERROR} state_t;
    localparam state_t S_END = S_DONE;
`endif

    state_t                  state_q, state_d;
    logic [7:0]              len_lo_q, len_lo_d;
    logic [15:0]             len_q, len_d;
    logic [BW-1:0]           byte_idx_q, byte_idx_d;
    logic [WORD_WIDTH-1:0]   word_q, word_d;
    logic [TW-1:0]           tmr_q, tmr_d;
    logic                    mem_we_q, mem_we_d;
    logic [ADDR_WIDTH-1:0]   mem_addr_q, mem_addr_d;
    logic [WORD_WIDTH-1:0]   mem_wdata_q, mem_wdata_d;
    logic [15:0]             word_count_q, word_count_d;
    logic                    hold_q, done_q, error_q;
`ifdef UART_LOADER_CHECKSUM_EN
    logic [7:0]              csum_q, csum_d;
`endif
    logic                    busy;
    logic                    timeout_hit;
    logic [15:0]             len_rx;

    // Next-state and datapath; abort overrides everything and leaves the datapath untouched
    always_comb begin
        state_d      = state_q;
        len_lo_d     = len_lo_q;
        len_d        = len_q;
        byte_idx_d   = byte_idx_q;
        word_d       = word_q;
        mem_we_d     = 1'b0;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        word_count_d = word_count_q;
`ifdef UART_LOADER_CHECKSUM_EN
        csum_d       = csum_q;
`endif
        len_rx       = {rx_data_i, len_lo_q};
        busy         = !(state_q inside {S_IDLE, S_DONE, S_ERROR});
        timeout_hit  = (TIMEOUT_CYCLES != 0) && busy && !rx_valid_i &&
                       ((32'(tmr_q) + 32'd1) == 32'(TIMEOUT_CYCLES));
        tmr_d        = (busy && !rx_valid_i && TIMEOUT_CYCLES != 0) ? tmr_q + TW'(1) : '0;

        if (abort_i) begin
            state_d = S_IDLE;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (enable_i) begin
                        state_d      = S_LEN0;
                        byte_idx_d   = '0;
                        word_d       = '0;
                        word_count_d = '0;
`ifdef UART_LOADER_CHECKSUM_EN
                        csum_d       = '0;
`endif
                    end
                end
                S_LEN0: if (rx_valid_i) begin
                    len_lo_d = rx_data_i;
                    state_d  = S_LEN1;
                end
                S_LEN1: if (rx_valid_i) begin
                    len_d = len_rx;
                    if (32'(len_rx) > 32'(MAX_WORDS)) state_d = S_ERROR;
                    else if (len_rx == 16'd0)         state_d = S_END;
                    else                              state_d = S_DATA;
                end
                S_DATA: if (rx_valid_i) begin
                    word_d[8*int'(byte_idx_q) +: 8] = rx_data_i;
`ifdef UART_LOADER_CHECKSUM_EN
                    csum_d = csum_q + rx_data_i;
`endif
                    if (byte_idx_q == BW'(BYTES - 1)) begin
                        byte_idx_d   = '0;
                        mem_we_d     = 1'b1;
                        mem_wdata_d  = word_d;
                        mem_addr_d   = BASE_ADDR + ADDR_WIDTH'(BYTES) * ADDR_WIDTH'(word_count_q);
                        word_count_d = word_count_q + 16'd1;
                        if (word_count_q == len_q - 16'd1) state_d = S_END;
                    end else begin
                        byte_idx_d = byte_idx_q + BW'(1);
                    end
                end
`ifdef UART_LOADER_CHECKSUM_EN
                S_CSUM: if (rx_valid_i) begin
                    state_d = (rx_data_i == csum_q) ? S_DONE : S_ERROR;
                end
`endif
                S_DONE, S_ERROR: if (!enable_i) state_d = S_IDLE;
                default: state_d = S_IDLE;
            endcase
            if (timeout_hit) state_d = S_ERROR;
        end
    end

    // State and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            len_lo_q     <= '0;
            len_q        <= '0;
            byte_idx_q   <= '0;
            word_q       <= '0;
            tmr_q        <= '0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= BASE_ADDR;
            mem_wdata_q  <= '0;
            word_count_q <= '0;
            hold_q       <= 1'b0;
            done_q       <= 1'b0;
            error_q      <= 1'b0;
`ifdef UART_LOADER_CHECKSUM_EN
            csum_q       <= '0;
`endif
        end else begin
            state_q      <= state_d;
            len_lo_q     <= len_lo_d;
            len_q        <= len_d;
            byte_idx_q   <= byte_idx_d;
            word_q       <= word_d;
            tmr_q        <= tmr_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            word_count_q <= word_count_d;
            hold_q       <= !(state_d inside {S_IDLE, S_DONE, S_ERROR});
            done_q       <= (state_d == S_DONE);
            error_q      <= (state_d == S_ERROR);
`ifdef UART_LOADER_CHECKSUM_EN
            csum_q       <= csum_d;
`endif
        end
    end

    assign mem_we_o     = mem_we_q;
    assign mem_addr_o   = mem_addr_q;
    assign mem_wdata_o  = mem_wdata_q;
    assign word_count_o = word_count_q;
    assign cpu_hold_o   = hold_q;
    assign done_o       = done_q;
    assign error_o      = error_q;
endmodule
